rgb_pattern_gen: RTL and testbench

Pixel-source stage placed directly downstream of rgb_timing in LCD test designs.
- Consumes rgb_timing's hs/vs/de and x/y coordinates.
- Generates one of eight test patterns.
- Delays the sync signals to match the pixel pipeline, then drives lcd_hs/lcd_vs/lcd_de/lcd_rgb.
- Pattern changes only at frame boundaries; patterns are selected manually or auto-cycled on a frame counter.

---
 rtl/rgb_pattern_gen_if.sv | 38 +++
 rtl/rgb_pattern_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_rgb_pattern_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// rgb_pattern_gen_if
// Bundles the timing inputs, pattern controls and LCD-side outputs of
// rgb_pattern_gen. Clock and reset stay outside the interface.
//   master : timing source / controller (drives in_*, auto_mode, pat_sel)
//   slave  : rgb_pattern_gen (drives out_*, pat_idx)
// Signals:
//   in_hs, in_vs, in_de   sync/enable from rgb_timing
//   in_x, in_y            pixel coordinates, valid while in_de=1
//   auto_mode, pat_sel    pattern selection controls
//   out_hs/out_vs/out_de  syncs delayed to match the pixel pipeline
//   out_rgb               pixel {R,G,B}
//   pat_idx               pattern currently displayed
// ---------------------------------------------------------------------------
interface rgb_pattern_gen_if;
  logic        in_hs;
  logic        in_vs;
  logic        in_de;
  logic [9:0]  in_x;
  logic [9:0]  in_y;
  logic        auto_mode;
  logic [2:0]  pat_sel;
  logic        out_hs;
  logic        out_vs;
  logic        out_de;
  logic [23:0] out_rgb;
  logic [2:0]  pat_idx;

  modport master (
    output in_hs, in_vs, in_de, in_x, in_y, auto_mode, pat_sel,
    input  out_hs, out_vs, out_de, out_rgb, pat_idx
  );

  modport slave (
    input  in_hs, in_vs, in_de, in_x, in_y, auto_mode, pat_sel,
    output out_hs, out_vs, out_de, out_rgb, pat_idx
  );
endinterface

// File: rtl/rgb_pattern_gen.sv
// ---------------------------------------------------------------------------
// rgb_pattern_gen
// Pixel source placed after rgb_timing. Produces one of eight test patterns
// with a 2-cycle pipeline and delays hs/vs/de to stay aligned with the pixel.
// The pattern only changes on a frame tick (inactive->active edge of in_vs),
// either from pat_sel (manual) or from a frame counter (auto).
//
// Ports:
//   rgb_clk    pixel clock, rising edge
//   rgb_rst_n  synchronous reset, active low
//   bus        rgb_pattern_gen_if.slave (timing in, controls, LCD out)
//
// Optional build macro:
//   RGB_PAT_OSD_EN  draws three 8x8 squares at the top-left showing pat_idx
//                   (white = bit set, red = bit clear) over every pattern.
// ---------------------------------------------------------------------------
module rgb_pattern_gen #(
  parameter int H_ACTIVE       = 800,
  parameter int V_ACTIVE       = 480,
  parameter int FRAMES_PER_PAT = 120,
  parameter int VS_ACTIVE_LOW  = 1,
  parameter int BAR_STEP       = 4
) (
  input  logic             rgb_clk,
  input  logic             rgb_rst_n,
  rgb_pattern_gen_if.slave bus
);

  localparam int              CNT_W       = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAMES_PER_PAT - 1);
  localparam logic [9:0]      X_LAST      = 10'(H_ACTIVE - 1);
  localparam logic [9:0]      Y_LAST      = 10'(V_ACTIVE - 1);
  localparam logic            VS_INACTIVE = (VS_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Coordinates beyond the active area are pinned to the last column/row.
  function automatic logic [9:0] clamp_x(input logic [9:0] x);
    return (x > X_LAST) ? X_LAST : x;
  endfunction

  function automatic logic [9:0] clamp_y(input logic [9:0] y);
    return (y > Y_LAST) ? Y_LAST : y;
  endfunction

  // Column = floor(x*24/H_ACTIVE): x crosses into column k at ceil(k*H/24).
  function automatic logic [4:0] col_of_24(input logic [9:0] x);
    logic [4:0] c;
    c = '0;
    for (int k = 1; k < 24; k++)
      if (int'(x) >= (k * H_ACTIVE + 23) / 24) c = c + 5'd1;
    return c;
  endfunction

  function automatic logic [2:0] col_of_8(input logic [9:0] x);
    logic [2:0] c;
    c = '0;
    for (int k = 1; k < 8; k++)
      if (int'(x) >= (k * H_ACTIVE + 7) / 8) c = c + 3'd1;
    return c;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Frame control state
  logic             vs_hist;
  logic [2:0]       pat_idx_q;
  logic [CNT_W-1:0] frame_cnt;
  logic [9:0]       bar_pos;

  logic             vs_act;
  logic             vs_hist_act;
  logic             tick;
  logic [10:0]      bar_nxt;

  assign vs_act      = (VS_ACTIVE_LOW != 0) ? ~bus.in_vs : bus.in_vs;
  assign vs_hist_act = (VS_ACTIVE_LOW != 0) ? ~vs_hist   : vs_hist;
  assign tick        = vs_act & ~vs_hist_act;
  assign bar_nxt     = {1'b0, bar_pos} + 11'(BAR_STEP);

  always_ff @(posedge rgb_clk) begin
    if (!rgb_rst_n) begin
      vs_hist   <= VS_INACTIVE;
      pat_idx_q <= '0;
      frame_cnt <= '0;
      bar_pos   <= '0;
    end else begin
      vs_hist <= bus.in_vs;
      if (tick) begin
        bar_pos <= (bar_nxt >= 11'(H_ACTIVE)) ? 10'd0 : bar_nxt[9:0];
        if (bus.auto_mode) begin
          if (frame_cnt == CNT_LAST) begin
            frame_cnt <= '0;
            pat_idx_q <= pat_idx_q + 3'd1;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end else begin
          pat_idx_q <= bus.pat_sel;
        end
      end
    end
  end

  // ---- Stage 1: clamp coordinates, derive per-pattern features ----
  logic [9:0]  x_c;
  logic [9:0]  y_c;
  logic        bar_hit;
  logic        brd_hit;

  assign x_c     = clamp_x(bus.in_x);
  assign y_c     = clamp_y(bus.in_y);
  assign bar_hit = ({1'b0, x_c} >= {1'b0, bar_pos}) &&
                   ({1'b0, x_c} <  ({1'b0, bar_pos} + 11'd16));
  assign brd_hit = (x_c == 10'd0) || (x_c == X_LAST) ||
                   (y_c == 10'd0) || (y_c == Y_LAST);

  logic        hs_p1;
  logic        vs_p1;
  logic        vld_p1;
  logic [4:0]  col24_p1;
  logic [2:0]  col8_p1;
  logic [7:0]  grey_p1;
  logic        chk_p1;
  logic        bar_p1;
  logic        brd_p1;
  logic [2:0]  pat_p1;
`ifdef RGB_PAT_OSD_EN
  logic        osd_hit_p1;
  logic [1:0]  osd_sq_p1;
`endif

  // pat_p1 captures pat_idx alongside the pixel, so a pixel coinciding with
  // a tick is rendered with the pattern that was active before the tick.
  always_ff @(posedge rgb_clk) begin
    if (!rgb_rst_n) begin
      hs_p1      <= 1'b0;
      vs_p1      <= 1'b0;
      vld_p1     <= 1'b0;
      col24_p1   <= '0;
      col8_p1    <= '0;
      grey_p1    <= '0;
      chk_p1     <= 1'b0;
      bar_p1     <= 1'b0;
      brd_p1     <= 1'b0;
      pat_p1     <= '0;
`ifdef RGB_PAT_OSD_EN
      osd_hit_p1 <= 1'b0;
      osd_sq_p1  <= '0;
`endif
    end else begin
      hs_p1      <= bus.in_hs;
      vs_p1      <= bus.in_vs;
      vld_p1     <= bus.in_de;
      col24_p1   <= col_of_24(x_c);
      col8_p1    <= col_of_8(x_c);
      grey_p1    <= x_c[9:2];
      chk_p1     <= x_c[5] ^ y_c[5];
      bar_p1     <= bar_hit;
      brd_p1     <= brd_hit;
      pat_p1     <= pat_idx_q;
`ifdef RGB_PAT_OSD_EN
      osd_hit_p1 <= (y_c < 10'd8) && (x_c < 10'd24);
      osd_sq_p1  <= x_c[4:3];
`endif
    end
  end

  // ---- Stage 2: pattern mux (and overlay), blanking ----
  logic [23:0] rgb_mux;

  always_comb begin
    rgb_mux = 24'h000000;
    case (pat_p1)
      3'd0:    rgb_mux = 24'h800000 >> col24_p1;
      3'd1:    rgb_mux = bar_colour(col8_p1);
      3'd2:    rgb_mux = {grey_p1, grey_p1, grey_p1};
      3'd3:    rgb_mux = chk_p1 ? 24'hFFFFFF : 24'h000000;
      3'd4:    rgb_mux = bar_p1 ? 24'hFFFFFF : 24'h0000FF;
      3'd5:    rgb_mux = 24'hFFFFFF;
      3'd6:    rgb_mux = brd_p1 ? 24'hFFFFFF : 24'h000000;
      default: rgb_mux = 24'h000000;
    endcase
`ifdef RGB_PAT_OSD_EN
    // Leftmost square shows the MSB.
    if (osd_hit_p1) begin
      case (osd_sq_p1)
        2'd0:    rgb_mux = pat_p1[2] ? 24'hFFFFFF : 24'hFF0000;
        2'd1:    rgb_mux = pat_p1[1] ? 24'hFFFFFF : 24'hFF0000;
        default: rgb_mux = pat_p1[0] ? 24'hFFFFFF : 24'hFF0000;
      endcase
    end
`endif
  end

  logic        hs_p2;
  logic        vs_p2;
  logic        vld_p2;
  logic [23:0] rgb_p2;

  always_ff @(posedge rgb_clk) begin
    if (!rgb_rst_n) begin
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      vld_p2 <= 1'b0;
      rgb_p2 <= '0;
    end else begin
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      vld_p2 <= vld_p1;
      rgb_p2 <= vld_p1 ? rgb_mux : 24'h000000;
    end
  end

  assign bus.out_hs  = hs_p2;
  assign bus.out_vs  = vs_p2;
  assign bus.out_de  = vld_p2;
  assign bus.out_rgb = rgb_p2;
  assign bus.pat_idx = pat_idx_q;

endmodule

// File: tb/tb_rgb_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_rgb_pattern_gen
// Directed bench for rgb_pattern_gen (H_ACTIVE=800, V_ACTIVE=480,
// FRAMES_PER_PAT=2, in_vs active low). Frames are abbreviated: a one-cycle
// vsync pulse produces the frame tick, followed by only the pixels of
// interest, each pushed through the 2-cycle pipeline and compared.
// ---------------------------------------------------------------------------
module tb_rgb_pattern_gen;
  logic rgb_clk = 1'b0;
  logic rgb_rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  rgb_pattern_gen_if bus ();

  rgb_pattern_gen #(
    .H_ACTIVE      (800),
    .V_ACTIVE      (480),
    .FRAMES_PER_PAT(2),
    .VS_ACTIVE_LOW (1),
    .BAR_STEP      (4)
  ) dut (
    .rgb_clk  (rgb_clk),
    .rgb_rst_n(rgb_rst_n),
    .bus      (bus)
  );

  always #5 rgb_clk = ~rgb_clk;

  task automatic step();
    @(posedge rgb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One-cycle active-low vsync pulse; pat_idx has updated when this returns.
  task automatic frame_tick();
    bus.in_de = 1'b0;
    bus.in_vs = 1'b0;
    step();
    bus.in_vs = 1'b1;
    step();
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    bus.in_x  = 10'(x);
    bus.in_y  = 10'(y);
    bus.in_de = 1'b1;
    step();
    bus.in_de = 1'b0;
    step();
    chk(tag, bus.out_rgb, exp);
  endtask

  task automatic do_reset();
    rgb_rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_hs = i[0];
      bus.in_vs = ~i[0];
      bus.in_de = i[0];
      bus.in_x  = 10'(i * 37);
      bus.in_y  = 10'(i * 11);
      step();
      chk("rst_hs",  24'(bus.out_hs), 24'h0);
      chk("rst_vs",  24'(bus.out_vs), 24'h0);
      chk("rst_de",  24'(bus.out_de), 24'h0);
      chk("rst_rgb", bus.out_rgb, 24'h0);
      chk("rst_pat", 24'(bus.pat_idx), 24'h0);
    end
    bus.in_hs = 1'b0;
    bus.in_vs = 1'b1;
    bus.in_de = 1'b0;
    rgb_rst_n = 1'b1;
    step();
  endtask

  initial begin
    bus.auto_mode = 1'b0;
    bus.pat_sel   = 3'd0;
    bus.in_hs     = 1'b0;
    bus.in_vs     = 1'b1;
    bus.in_de     = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    do_reset();

    // Latency of de/hs/vs and the first pixel (pattern 0 after reset)
    bus.in_hs = 1'b1;
    bus.in_de = 1'b1;
    bus.in_x  = 10'd0;
    bus.in_y  = 10'd100;
    step();
    chk("lat_de_1", 24'(bus.out_de), 24'h0);
    chk("lat_hs_1", 24'(bus.out_hs), 24'h0);
    bus.in_hs = 1'b0;
    bus.in_de = 1'b0;
    step();
    chk("lat_de_2", 24'(bus.out_de), 24'h1);
    chk("lat_hs_2", 24'(bus.out_hs), 24'h1);
    chk("lat_rgb",  bus.out_rgb, 24'h800000);
    step();
    chk("lat_de_3", 24'(bus.out_de), 24'h0);
    bus.in_vs = 1'b0;
    step();
    bus.in_vs = 1'b1;
    step();
    chk("lat_vs_2", 24'(bus.out_vs), 24'h0);
    step();
    chk("lat_vs_3", 24'(bus.out_vs), 24'h1);

    // Bit-walk
    pix("bw_x0",   0,   100, 24'h800000);
    pix("bw_x33",  33,  100, 24'h800000);
    pix("bw_x34",  34,  100, 24'h400000);
    pix("bw_x799", 799, 100, 24'h000001);
    pix("bw_clamp", 900, 100, 24'h000001);
    bus.in_x = 10'd0;
    step();
    step();
    chk("bw_blank", bus.out_rgb, 24'h000000);

    // Manual select: colour bars, then a mid-frame pat_sel change
    bus.pat_sel = 3'd1;
    frame_tick();
    chk("man_pat1", 24'(bus.pat_idx), 24'h1);
    pix("cb_x0",   0,   100, 24'hFFFFFF);
    pix("cb_x150", 150, 100, 24'hFFFF00);
    pix("cb_x350", 350, 100, 24'h00FF00);
    pix("cb_x799", 799, 100, 24'h000000);
    bus.pat_sel = 3'd5;
    step();
    pix("cb_hold", 150, 100, 24'hFFFF00);
    chk("man_hold", 24'(bus.pat_idx), 24'h1);
    frame_tick();
    chk("man_pat5", 24'(bus.pat_idx), 24'h5);
    pix("solid5", 150, 100, 24'hFFFFFF);
`ifdef RGB_PAT_OSD_EN
    pix("osd_2_2",  2,  2, 24'hFFFFFF);
    pix("osd_10_2", 10, 2, 24'hFF0000);
    pix("osd_18_2", 18, 2, 24'hFFFFFF);
    pix("osd_30_2", 30, 2, 24'hFFFFFF);
`endif

    // Grey ramp
    bus.pat_sel = 3'd2;
    frame_tick();
    pix("grey_400", 400, 100, 24'h646464);
    pix("grey_799", 799, 100, 24'hC7C7C7);

    // Checker
    bus.pat_sel = 3'd3;
    frame_tick();
    pix("chk_32_100", 32, 100, 24'h000000);
    pix("chk_0_100",  0,  100, 24'hFFFFFF);
    pix("chk_32_64",  32, 64,  24'hFFFFFF);

    // Border
    bus.pat_sel = 3'd6;
    frame_tick();
    pix("brd_0_100",   0,   100, 24'hFFFFFF);
    pix("brd_5_100",   5,   100, 24'h000000);
    pix("brd_5_479",   5,   479, 24'hFFFFFF);
    pix("brd_5_600",   5,   600, 24'hFFFFFF);
    pix("brd_900_100", 900, 100, 24'hFFFFFF);
    pix("brd_100_0",   100, 0,   24'hFFFFFF);

    // Solid black
    bus.pat_sel = 3'd7;
    frame_tick();
    pix("black", 400, 100, 24'h000000);

    // Moving bar from a fresh reset (bar_pos = 4 after first tick)
    do_reset();
    bus.pat_sel = 3'd4;
    frame_tick();
    chk("mb_pat", 24'(bus.pat_idx), 24'h4);
    pix("mb_x4",  4,  100, 24'hFFFFFF);
    pix("mb_x3",  3,  100, 24'h0000FF);
    pix("mb_x19", 19, 100, 24'hFFFFFF);
    pix("mb_x20", 20, 100, 24'h0000FF);
    for (int f = 0; f < 198; f++) frame_tick();
    pix("mb796_x799", 799, 100, 24'hFFFFFF);
    pix("mb796_x796", 796, 100, 24'hFFFFFF);
    pix("mb796_x795", 795, 100, 24'h0000FF);
    frame_tick();
    pix("mb0_x0",  0,  100, 24'hFFFFFF);
    pix("mb0_x15", 15, 100, 24'hFFFFFF);
    pix("mb0_x16", 16, 100, 24'h0000FF);

    // Auto cycle, 2 frames per pattern
    do_reset();
    bus.auto_mode = 1'b1;
    bus.pat_sel   = 3'd0;
    for (int f = 1; f <= 16; f++) begin
      frame_tick();
      chk($sformatf("auto_f%0d", f), 24'(bus.pat_idx), 24'((f / 2) % 8));
    end
    frame_tick();
    chk("auto_f17", 24'(bus.pat_idx), 24'h0);
    bus.auto_mode = 1'b0;
    bus.pat_sel   = 3'd3;
    step();
    chk("a2m_nochange", 24'(bus.pat_idx), 24'h0);
    frame_tick();
    chk("a2m_tick", 24'(bus.pat_idx), 24'h3);
    bus.auto_mode = 1'b1;
    frame_tick();
    chk("m2a_resume", 24'(bus.pat_idx), 24'h4);

    // Tick coinciding with de: pixel uses pre-tick pattern (moving bar,
    // bar_pos = 76 before this tick)
    bus.auto_mode = 1'b0;
    bus.pat_sel   = 3'd5;
    bus.in_vs     = 1'b0;
    bus.in_de     = 1'b1;
    bus.in_x      = 10'd300;
    bus.in_y      = 10'd100;
    step();
    bus.in_vs = 1'b1;
    bus.in_de = 1'b0;
    step();
    chk("tickde_rgb", bus.out_rgb, 24'h0000FF);
    chk("tickde_pat", 24'(bus.pat_idx), 24'h5);
    pix("tickde_after", 300, 100, 24'hFFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
